pe_sequencer: RTL and testbench
===============================

PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of step count and step address.
REQ-002 SHALL have parameter PHASES, default 4, cycles per MAC step; fixed at 4, phase index 2 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  request to run a MAC sequence; sampled only in IDLE.
REQ-006 num_steps  input  CNT_W  number of MAC steps; latched on accepted start.
REQ-007 stall  input  1  freeze request from the PE datapath.
REQ-008 pe_load  output  1  operand-load strobe (phase 0).
REQ-009 pe_mul  output  1  multiply strobe (phase 1).
REQ-010 pe_acc  output  1  accumulate strobe (phase 2).
REQ-011 pe_wb  output  1  write-back strobe (phase 3).
REQ-012 acc_clr  output  1  accumulator clear; concurrent with pe_load of step 0 only.
REQ-013 addr  output  CNT_W  current step index for operand fetch.
REQ-014 busy  output  1  high in RUN and DONE.
REQ-015 done  output  1  single-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 IDLE: start=1 with num_steps!=0 -> RUN, phase=0, addr=0, num_steps latched.
REQ-018 IDLE: start=1 with num_steps=0 -> DONE directly; no phase strobes are issued.
REQ-019 RUN: without stall, phase SHALL advance 0->1->2->3->0 each cycle.
REQ-020 On phase wrap 3->0, addr SHALL increment by 1.
REQ-021 At phase 3 with addr = latched num_steps-1 and stall=0, next state SHALL be DONE; addr does not increment.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 Strobes SHALL be decoded from state and phase.
REQ-024 Exactly one of pe_load/pe_mul/pe_acc/pe_wb SHALL be high in an unstalled RUN cycle; all SHALL be low outside RUN.
REQ-025 stall=1 in RUN SHALL freeze phase and addr and force all strobes and acc_clr low; on release, the frozen phase's strobe reissues.
REQ-026 Latency: start accepted in cycle 0 gives pe_load in cycle 1 and done in cycle 4N+1 plus the number of stalled RUN cycles.
REQ-027 start in RUN or DONE SHALL be ignored; num_steps changes after acceptance SHALL have no effect.
REQ-028 num_steps = 2^CNT_W-1 SHALL complete without addr wrap; addr never exceeds num_steps-1.
REQ-029 Stall in the final phase-3 cycle SHALL delay DONE until the cycle after stall deasserts.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, phase=0, addr=0 and latched count=0, independent of clk.
REQ-031 In reset, all outputs SHALL be 0.
REQ-032 Reset mid-RUN SHALL abort with no done pulse; the next start after release behaves as a fresh run.

Structure
REQ-033 Shared package pe_ctrl_pkg SHALL hold the state enum and the phase constants PH_LOAD=0, PH_MUL=1, PH_ACC=2, PH_WB=3.
REQ-034 Phase counting SHALL be a sub-module mac_phase_counter: 2-bit, enable, synchronous clear, asynchronous active-high reset, wraps 3->0.
REQ-035 RTL SHALL be synthesizable with no latches.

Verification
REQ-036 start with num_steps=3, no stall -> strobe sequence L,M,A,W x3; addr 0,1,2; acc_clr only in cycle 1; done in cycle 13.
REQ-037 start with num_steps=0 -> done in cycle 1; no strobes; busy high in cycle 1 only.
REQ-038 num_steps=2, stall high for 3 cycles during step 1 phase 2 -> pe_acc low during stall, reissued after release; done in cycle 12.
REQ-039 rst asserted mid-RUN at addr=1 -> outputs 0 asynchronously; no done; a new start with num_steps=1 gives done at cycle 5.
REQ-040 start pulsed in RUN and in the DONE cycle -> ignored; exactly one done per accepted start.
REQ-041 CNT_W=4, num_steps=15 -> addr reaches 14, no wrap; done in cycle 61.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE MAC sequencer: FSM state encoding and the
// phase indices that select each datapath strobe.
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pe_state_e;

  localparam logic [1:0] PH_LOAD = 2'd0;
  localparam logic [1:0] PH_MUL  = 2'd1;
  localparam logic [1:0] PH_ACC  = 2'd2;
  localparam logic [1:0] PH_WB   = 2'd3;

endpackage

// File: rtl/mac_phase_counter.sv
// Two-bit MAC phase counter; wraps 3->0 through natural overflow.
module mac_phase_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [1:0] phase
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase <= 2'd0;
    else if (clr)
      phase <= 2'd0;
    else if (en)
      phase <= phase + 2'd1;
  end

endmodule

// File: rtl/pe_sequencer.sv
// Sequences num_steps four-phase MAC steps (load, multiply, accumulate,
// write-back) into a PE datapath, with stall freeze and a done pulse.
//
//   state | meaning
//   IDLE  | waiting for start; num_steps latched on acceptance
//   RUN   | issuing phase strobes, addr = current step
//   DONE  | one-cycle completion pulse, then back to IDLE
module pe_sequencer
  import pe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int PHASES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_steps,
  input  logic             stall,
  output logic             pe_load,
  output logic             pe_mul,
  output logic             pe_acc,
  output logic             pe_wb,
  output logic             acc_clr,
  output logic [CNT_W-1:0] addr,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] PH_LAST = 2'(PHASES - 1);

  pe_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] addr_q, addr_d;
  logic [1:0]       phase;
  logic             run;
  logic             adv;
  logic             last_step;

  assign run       = (state_q == ST_RUN);
  assign adv       = run && !stall;
  assign last_step = (addr_q == cnt_q - CNT_W'(1));

  mac_phase_counter u_phase (
    .clk   (clk),
    .rst   (rst),
    .en    (adv),
    .clr   (!run),
    .phase (phase)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = num_steps;
          addr_d  = '0;
          state_d = (num_steps == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // The final write-back ends the run without bumping addr past num_steps-1.
        if (adv && phase == PH_LAST) begin
          if (last_step)
            state_d = ST_DONE;
          else
            addr_d = addr_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pe_load = adv && (phase == PH_LOAD);
  assign pe_mul  = adv && (phase == PH_MUL);
  assign pe_acc  = adv && (phase == PH_ACC);
  assign pe_wb   = adv && (phase == PH_WB);
  assign acc_clr = adv && (phase == PH_LOAD) && (addr_q == '0);
  assign addr    = addr_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed scoreboard bench for pe_sequencer: per-cycle expectations are queued
// with their stimulus and compared as the DUT runs.
module tb_pe_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stall;
  logic [7:0] num_steps;
  logic       pe_load, pe_mul, pe_acc, pe_wb, acc_clr, busy, done;
  logic [7:0] addr;

  logic       start4;
  logic [3:0] num_steps4;
  logic       pe_load4, pe_mul4, pe_acc4, pe_wb4, acc_clr4, busy4, done4;
  logic [3:0] addr4;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       st_start;
    logic       st_stall;
    logic [7:0] st_num;
    logic [3:0] strb;
    logic       clr;
    logic       addr_chk;
    logic [7:0] addr;
    logic       busy;
    logic       done;
  } rec_t;

  rec_t q[$];

  always #5 clk = ~clk;

  pe_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .num_steps(num_steps), .stall(stall),
    .pe_load(pe_load), .pe_mul(pe_mul), .pe_acc(pe_acc), .pe_wb(pe_wb),
    .acc_clr(acc_clr), .addr(addr), .busy(busy), .done(done)
  );

  pe_sequencer #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .num_steps(num_steps4), .stall(stall),
    .pe_load(pe_load4), .pe_mul(pe_mul4), .pe_acc(pe_acc4), .pe_wb(pe_wb4),
    .acc_clr(acc_clr4), .addr(addr4), .busy(busy4), .done(done4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic s_start, input logic s_stall, input logic [7:0] s_num,
                      input logic [3:0] strb, input logic clr, input logic achk,
                      input logic [7:0] a, input logic b, input logic d);
    rec_t r;
    r.st_start = s_start; r.st_stall = s_stall; r.st_num = s_num;
    r.strb = strb; r.clr = clr; r.addr_chk = achk; r.addr = a; r.busy = b; r.done = d;
    q.push_back(r);
  endtask

  // n steps; optional stall of sl cycles just before step ss phase sp;
  // inj pulses start (with a changed count) inside RUN and in DONE;
  // max_run truncates the RUN portion (no DONE/IDLE records then).
  task automatic plan_run(input int n, input int ss, input int sp, input int sl,
                          input bit inj, input int max_run);
    int k = 0;
    logic [7:0] nn = 8'(n);
    logic [7:0] nj = 8'(n + 5);
    push(1'b1, 1'b0, nn, 4'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    for (int s = 0; s < n; s++) begin
      for (int p = 0; p < 4; p++) begin
        if (s == ss && p == sp) begin
          for (int i = 0; i < sl; i++) begin
            if (k >= max_run) return;
            push(inj && (k % 3 == 1), 1'b1, (inj && (k % 3 == 1)) ? nj : nn,
                 4'b0, 1'b0, 1'b1, 8'(s), 1'b1, 1'b0);
            k++;
          end
        end
        if (k >= max_run) return;
        push(inj && (k % 3 == 1), 1'b0, (inj && (k % 3 == 1)) ? nj : nn,
             4'(1 << p), (s == 0 && p == 0), 1'b1, 8'(s), 1'b1, 1'b0);
        k++;
      end
    end
    push(inj, 1'b0, inj ? nj : nn, 4'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    push(1'b0, 1'b0, nn, 4'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic play(input string tag);
    rec_t r;
    int cyc = 0;
    logic [7:0] oa, ea;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk);
      #1;
      start = r.st_start; stall = r.st_stall; num_steps = r.st_num;
      @(negedge clk);
      oa = r.addr_chk ? addr : 8'd0;
      ea = r.addr_chk ? r.addr : 8'd0;
      chk($sformatf("%s cyc%0d", tag, cyc),
          {17'd0, pe_wb, pe_acc, pe_mul, pe_load, acc_clr, busy, done, oa},
          {17'd0, r.strb, r.clr, r.busy, r.done, ea});
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc, max_a, loads;
    bit wrapped;
    logic [3:0] prev_a;

    rst = 1'b1; start = 1'b0; stall = 1'b0; num_steps = 8'd0;
    start4 = 1'b0; num_steps4 = 4'd0;
    #12;
    chk("reset_outputs", {pe_load, pe_mul, pe_acc, pe_wb, acc_clr, busy, done, addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    plan_run(3, -1, 0, 0, 1'b0, 1 << 30);
    play("n3");

    plan_run(0, -1, 0, 0, 1'b0, 1 << 30);
    play("n0");

    plan_run(2, 1, 2, 3, 1'b0, 1 << 30);
    play("stall_acc");

    plan_run(2, 1, 3, 2, 1'b0, 1 << 30);
    play("stall_last_wb");

    plan_run(3, 0, 1, 1, 1'b1, 1 << 30);
    play("ignore_start");

    // Abort a run at addr=1, then verify a fresh one-step run.
    plan_run(2, -1, 0, 0, 1'b0, 6);
    play("pre_reset");
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", {pe_load, pe_mul, pe_acc, pe_wb, acc_clr, busy, done, addr}, 32'd0);
    @(posedge clk);
    #1;
    chk("held_reset", {pe_load, pe_mul, pe_acc, pe_wb, acc_clr, busy, done, addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    plan_run(1, -1, 0, 0, 1'b0, 1 << 30);
    play("after_reset");

    plan_run(255, -1, 0, 0, 1'b0, 1 << 30);
    play("n255");

    // Narrow instance at full count.
    @(posedge clk);
    #1;
    start4 = 1'b1; num_steps4 = 4'd15;
    @(posedge clk);
    #1;
    start4 = 1'b0; num_steps4 = 4'd0;
    done_cyc = 0; max_a = 0; loads = 0; wrapped = 1'b0; prev_a = 4'd0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (busy4 && !done4) begin
        if (int'(addr4) > max_a) max_a = int'(addr4);
        if (addr4 < prev_a) wrapped = 1'b1;
        prev_a = addr4;
      end
      if (pe_load4) loads++;
      if (done4) begin
        done_cyc = cyc;
        break;
      end
    end
    chk("w4_done_cycle", 32'(done_cyc), 32'd61);
    chk("w4_max_addr", 32'(max_a), 32'd14);
    chk("w4_load_count", 32'(loads), 32'd15);
    chk("w4_no_wrap", {31'd0, wrapped}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
